swervolf_board_io: RTL
======================

// Module: swervolf_board_io
// PURPOSE
// Parametrised board I/O conditioner between board pins and swervolf_core GPIO/UART.
// Synchronises and debounces NUM_SW switches, pipelines NUM_LED LED outputs, and
// muxes two UART TX sources, switching only at a line-idle boundary so no frame is cut.
// Single clock domain (core clock); all inputs are treated as asynchronous.
// PARAMETERS
// NUM_SW           16      switch channel count (>=1)
// NUM_LED          16      LED channel count (>=1)
// DEBOUNCE_CYCLES  500000  consecutive cycles a new switch level must hold (>=1)
// UART_SEL_BIT     0       debounced switch index that selects the TX source (<NUM_SW)
// CLKS_PER_BIT     434     clock cycles per UART bit (>=1)
// IDLE_BITS        11      bit times both TX lines must be idle before a switch (>=1)
// PORTS
// i_clk        in   1        core clock
// i_rst        in   1        synchronous reset, active high
// i_sw         in   NUM_SW   raw switch pins
// o_sw         out  NUM_SW   debounced switch levels (to GPIO in)
// o_sw_event   out  NUM_SW   1-cycle pulse per channel when o_sw bit toggles
// i_led        in   NUM_LED  LED values from GPIO out
// o_led        out  NUM_LED  LED pins
// i_tx_cpu     in   1        TX from CPU UART (source 0)
// i_tx_aux     in   1        TX from auxiliary UART (source 1)
// o_uart_tx    out  1        TX pin, registered
// o_tx_sel     out  1        source currently driving o_uart_tx
// BEHAVIOUR
// - Reset (i_rst high at posedge): o_sw=0, o_sw_event=0, o_led=0, o_uart_tx=1,
//   o_tx_sel=0, all sync flops 0 except TX sync flops =1, counters 0, FSM SEL_CPU.
// - Switch path, per channel: 2-flop sync -> s. Counter cnt (clog2(DEBOUNCE_CYCLES+1)
//   bits): cleared when s==o_sw; else increments. When s!=o_sw and cnt==DEBOUNCE_CYCLES-1,
//   o_sw<=s, cnt<=0, o_sw_event<=1 that cycle. Glitch shorter than DEBOUNCE_CYCLES: no
//   change. Latency i_sw step -> o_sw: DEBOUNCE_CYCLES+2 cycles. Channels independent.
// - LED path: two register stages, latency 2 cycles, no other processing.
// - TX sync: each TX input through 2-flop sync (reset 1) -> tc, ta.
// - Idle counter ic, width clog2(IDLE_BITS*CLKS_PER_BIT+1): cleared when tc==0 or ta==0,
//   else increments, saturating at IDLE_MAX=IDLE_BITS*CLKS_PER_BIT. idle = (ic==IDLE_MAX).
// - Requested source req = o_sw[UART_SEL_BIT].
// - FSM: SEL_CPU, SEL_AUX, WAIT_IDLE (holds current o_tx_sel).
//   SEL_x: if req!=o_tx_sel -> WAIT_IDLE.
//   WAIT_IDLE: req==o_tx_sel -> back to SEL_(o_tx_sel) (request withdrawn, no switch);
//     else if idle -> o_tx_sel<=req, ic<=0, go SEL_(req). Idle and withdrawal same
//     cycle: withdrawal wins, no switch.
// - o_uart_tx <= o_tx_sel ? ta : tc every cycle; new source appears one cycle after
//   o_tx_sel updates. Line never driven low by the mux itself.
// - Reset mid-operation: all state returns to reset values next cycle; o_uart_tx idle high.
// TESTING (bench params: DEBOUNCE_CYCLES=4, CLKS_PER_BIT=4, IDLE_BITS=2, NUM_SW=4)
// - Reset: hold i_rst 2 cycles -> o_sw=0, o_led=0, o_uart_tx=1, o_tx_sel=0.
// - i_sw[2] 0->1 held -> o_sw[2]=1 exactly 6 cycles later, o_sw_event[2] high 1 cycle.
// - i_sw[1] pulse of 3 cycles -> o_sw[1] stays 0, no event; 4-cycle pulse -> toggles.
// - i_led=16'hA5A5 -> o_led=16'hA5A5 after 2 cycles.
// - i_sw[0]=1 while i_tx_cpu toggles each 4 cycles -> o_tx_sel stays 0; stop toggling
//   (both lines high) -> o_tx_sel=1 after 8 idle cycles, then o_uart_tx follows i_tx_aux.
// - In WAIT_IDLE release i_sw[0] debounced back to 0 -> FSM returns SEL_CPU, o_tx_sel=0.

Source files
------------

// File: rtl/swervolf_board_io_if.sv
// ----------------------------------------------------------------------------
// swervolf_board_io_if
// Bundles the board-side and core-side signals of swervolf_board_io.
//   i_sw        raw switch pins              (board  -> conditioner)
//   o_sw        debounced switch levels      (conditioner -> GPIO in)
//   o_sw_event  1-cycle toggle pulse per switch
//   i_led       LED values from GPIO out     (core -> conditioner)
//   o_led       LED pins
//   i_tx_cpu    TX from the CPU UART         (source 0)
//   i_tx_aux    TX from the auxiliary UART   (source 1)
//   o_uart_tx   TX pin
//   o_tx_sel    source currently driving o_uart_tx
// The master modport is the environment (board pins and core), and the slave
// modport is the conditioner itself.
// ----------------------------------------------------------------------------
interface swervolf_board_io_if #(
    parameter int NUM_SW  = 16,
    parameter int NUM_LED = 16
);
    logic [NUM_SW-1:0]  i_sw;
    logic [NUM_SW-1:0]  o_sw;
    logic [NUM_SW-1:0]  o_sw_event;
    logic [NUM_LED-1:0] i_led;
    logic [NUM_LED-1:0] o_led;
    logic               i_tx_cpu;
    logic               i_tx_aux;
    logic               o_uart_tx;
    logic               o_tx_sel;

    modport master (
        output i_sw, i_led, i_tx_cpu, i_tx_aux,
        input  o_sw, o_sw_event, o_led, o_uart_tx, o_tx_sel
    );

    modport slave (
        input  i_sw, i_led, i_tx_cpu, i_tx_aux,
        output o_sw, o_sw_event, o_led, o_uart_tx, o_tx_sel
    );
endinterface

// File: rtl/swervolf_board_io.sv
// ----------------------------------------------------------------------------
// swervolf_board_io
// Board I/O conditioner between the board pins and swervolf_core GPIO/UART.
//   - Each switch is synchronised with two flops and then debounced. A new level
//     must hold for DEBOUNCE_CYCLES consecutive cycles before o_sw follows it.
//   - LEDs pass through two register stages.
//   - Two UART TX sources are muxed onto o_uart_tx. The selection changes only
//     after both lines have been idle (high) for IDLE_BITS bit times, so no frame
//     is cut.
// Ports:
//   i_clk  core clock
//   i_rst  synchronous reset, active high
//   io     swervolf_board_io_if.slave (switch, LED and UART signals)
// All inputs in io are treated as asynchronous to i_clk.
// ----------------------------------------------------------------------------

// Per-channel switch synchroniser and debouncer.
//   clk_i/rst_i  clock, synchronous active-high reset
//   sw_i         raw switch pin
//   sw_o         debounced level
//   event_o      1-cycle pulse when sw_o toggles
module swervolf_board_io_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sw_i,
    output logic sw_o,
    output logic event_o
);
    localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          meta_q, sync_q;
    logic          sw_q, sw_d;
    logic          evt_q, evt_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Counter measures how long the synced level has disagreed with the output.
    // Any agreement clears it, so a shorter glitch never reaches CNT_LAST.
    always_comb begin
        sw_d  = sw_q;
        evt_d = 1'b0;
        cnt_d = '0;
        if (sync_q != sw_q) begin
            if (cnt_q == CNT_LAST) begin
                sw_d  = sync_q;
                evt_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            sw_q   <= 1'b0;
            evt_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            meta_q <= sw_i;
            sync_q <= meta_q;
            sw_q   <= sw_d;
            evt_q  <= evt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign sw_o    = sw_q;
    assign event_o = evt_q;
endmodule

module swervolf_board_io #(
    parameter int NUM_SW          = 16,
    parameter int NUM_LED         = 16,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int UART_SEL_BIT    = 0,
    parameter int CLKS_PER_BIT    = 434,
    parameter int IDLE_BITS       = 11
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    swervolf_board_io_if.slave   io
);
    localparam int            IDLE_MAX   = IDLE_BITS * CLKS_PER_BIT;
    localparam int            IW         = $clog2(IDLE_MAX + 1);
    localparam logic [IW-1:0] IDLE_MAX_V = IW'(IDLE_MAX);

    typedef enum logic [1:0] {
        SEL_CPU   = 2'd0,
        SEL_AUX   = 2'd1,
        WAIT_IDLE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Switches
    // ------------------------------------------------------------------
    logic [NUM_SW-1:0] sw_deb;
    logic [NUM_SW-1:0] sw_evt;

    for (genvar g = 0; g < NUM_SW; g++) begin : g_sw
        swervolf_board_io_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk_i  (i_clk),
            .rst_i  (i_rst),
            .sw_i   (io.i_sw[g]),
            .sw_o   (sw_deb[g]),
            .event_o(sw_evt[g])
        );
    end

    assign io.o_sw       = sw_deb;
    assign io.o_sw_event = sw_evt;

    // ------------------------------------------------------------------
    // LEDs: plain two-stage pipeline
    // ------------------------------------------------------------------
    logic [NUM_LED-1:0] led_s1_q, led_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            led_s1_q <= '0;
            led_q    <= '0;
        end else begin
            led_s1_q <= io.i_led;
            led_q    <= led_s1_q;
        end
    end

    assign io.o_led = led_q;

    // ------------------------------------------------------------------
    // UART TX sync, idle detection and source selection
    // ------------------------------------------------------------------
    logic          tc_meta_q, tc_q, ta_meta_q, ta_q;
    logic [IW-1:0] ic_q, ic_d;
    logic          idle;
    logic          req;
    logic          do_switch;
    state_t        state_q, state_d;
    logic          tx_sel_q, tx_sel_d;
    logic          uart_tx_q;

    assign idle = (ic_q == IDLE_MAX_V);
    assign req  = sw_deb[UART_SEL_BIT];

    // A request only takes effect from WAIT_IDLE, so it must be outstanding
    // for at least one cycle. Withdrawal is checked before idle, so if both
    // happen in the same cycle the request is dropped.
    always_comb begin
        state_d   = state_q;
        tx_sel_d  = tx_sel_q;
        do_switch = 1'b0;
        unique case (state_q)
            SEL_CPU, SEL_AUX: begin
                if (req != tx_sel_q) state_d = WAIT_IDLE;
            end
            WAIT_IDLE: begin
                if (req == tx_sel_q) begin
                    state_d = tx_sel_q ? SEL_AUX : SEL_CPU;
                end else if (idle) begin
                    tx_sel_d  = req;
                    do_switch = 1'b1;
                    state_d   = req ? SEL_AUX : SEL_CPU;
                end
            end
            default: state_d = SEL_CPU;
        endcase
    end

    // Either line low means a frame may be in flight. The count restarts after
    // a switch, so a later switch must wait for a fresh idle period.
    always_comb begin
        ic_d = ic_q;
        if (!tc_q || !ta_q || do_switch) begin
            ic_d = '0;
        end else if (!idle) begin
            ic_d = ic_q + IW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tc_meta_q <= 1'b1;
            tc_q      <= 1'b1;
            ta_meta_q <= 1'b1;
            ta_q      <= 1'b1;
            ic_q      <= '0;
            state_q   <= SEL_CPU;
            tx_sel_q  <= 1'b0;
            uart_tx_q <= 1'b1;
        end else begin
            tc_meta_q <= io.i_tx_cpu;
            tc_q      <= tc_meta_q;
            ta_meta_q <= io.i_tx_aux;
            ta_q      <= ta_meta_q;
            ic_q      <= ic_d;
            state_q   <= state_d;
            tx_sel_q  <= tx_sel_d;
            // Mux on the registered select, so a new source shows up one
            // cycle after o_tx_sel changes.
            uart_tx_q <= tx_sel_q ? ta_q : tc_q;
        end
    end

    assign io.o_uart_tx = uart_tx_q;
    assign io.o_tx_sel  = tx_sel_q;
endmodule
